cb_param_cfg: RTL and testbench
===============================

// Module: cb_param_cfg
// PURPOSE
//  Parametrised connection box with an integrated, parity-checked configuration chain.
//  It connects NUM_IN logic-block inputs to routing tracks and drives tracks from NUM_OUT logic-block outputs.
//  Configuration arrives serially through a token-passing daisy chain, is held in a shadow register,
//  and is committed to the active register only when global programming ends. Used in the FPGA fabric tile array.
// PARAMETERS
//  NUM_TRACKS  8  routing tracks per box; TW = max(1,clog2(NUM_TRACKS))
//  NUM_IN      4  logic-block inputs (x) fed from tracks
//  NUM_OUT     2  logic-block outputs (q) driven onto tracks; QW = max(1,clog2(NUM_OUT))
//  FRAME_LEN   derived = NUM_IN*(TW+1) + NUM_TRACKS*(QW+1) + 1
// PORTS
//  clk            in   1           fabric/config clock
//  reset          in   1           asynchronous, active-low reset
//  prgm_b         in   1           global program, active-low (0 = programming phase)
//  cb_prgm_b      in   1           box select, active-low
//  cb_prgm_b_in   in   1           config token from previous box, active-low
//  cb_prgm_b_out  out  1           config token to next box, active-low
//  bit_in         in   1           serial config data
//  cfg_done       out  1           active config valid
//  cfg_err        out  1           sticky parity/abort error
//  track_in       in   NUM_TRACKS  track values
//  track_out      out  NUM_TRACKS  values driven by this box
//  track_oe       out  NUM_TRACKS  per-track drive enable
//  lb_q           in   NUM_OUT     logic-block outputs
//  lb_x           out  NUM_IN      logic-block inputs
// BEHAVIOUR
//  Reset: shadow and active = 0, state IDLE, cnt = 0; cb_prgm_b_out=1, cfg_done=0, cfg_err=0, lb_x=0, track_oe=0, track_out=0.
//  Frame: shifted MSB-first (shadow <= {shadow[FRAME_LEN-2:0], bit_in}). Layout from MSB:
//    for i=0..NUM_IN-1: {in_en[i], in_sel[i][TW-1:0]}; then for t=0..NUM_TRACKS-1: {trk_en[t], trk_sel[t][QW-1:0]}; LSB=parity.
//    Valid frame: XOR over all FRAME_LEN bits == 0 (even parity).
//  FSM states (shared package): IDLE, SHIFT, CHECK, DONE, ERR.
//    IDLE  -> SHIFT when prgm_b=0 and cb_prgm_b=0 and cb_prgm_b_in=0; cnt=0.
//    SHIFT: shifts once per cycle while cb_prgm_b=0 and cb_prgm_b_in=0; otherwise holds shadow and cnt.
//      The first bit is captured in the IDLE->SHIFT cycle. Transition to CHECK after FRAME_LEN bits (cnt==FRAME_LEN-1 on a shift).
//      prgm_b=1 in SHIFT = abort: -> IDLE, no commit, cfg_err<=1.
//    CHECK (1 cycle): parity ok -> DONE, else -> ERR with cfg_err<=1.
//    DONE/ERR: cb_prgm_b_out=0 (token passed even on error) until prgm_b=1.
//      DONE + prgm_b=1: active <= shadow, cfg_done<=1, cfg_err<=0, -> IDLE.
//      ERR + prgm_b=1: active unchanged, -> IDLE.
//    cb_prgm_b_out returns to 1 in IDLE.
//  Datapath (combinational from active config; forced inactive while prgm_b=0):
//    lb_x[i] = in_en[i] && in_sel[i] < NUM_TRACKS ? track_in[in_sel[i]] : 0.
//    track_oe[t] = trk_en[t] && trk_sel[t] < NUM_OUT; track_out[t] = track_oe[t] ? lb_q[trk_sel[t]] : 0.
//    An out-of-range select behaves as disabled.
//  Latency: config commit is visible the cycle after prgm_b is sampled high in DONE; the datapath has zero latency.
//  Reset mid-operation: immediate return to the reset state; any partial frame is discarded.
// STRUCTURE
//  Package cb_cfg_pkg contains: the state enum, a clog2-based width function (TW/QW), a FRAME_LEN function,
//    and field-offset constants for the frame layout.
//  Sub-module cb_cfg_chain contains the FSM, counter, shadow/active registers, parity and token logic.
//    It outputs the decoded active fields.
//  The top-level contains the select muxes only.
// TESTING  (NUM_TRACKS=8, NUM_IN=4, NUM_OUT=2 -> TW=3, QW=1, FRAME_LEN=33)
//  1. Program in_en0=1, in_sel0=5 with correct parity, then set prgm_b high.
//     -> cfg_done=1; track_in=8'h20 gives lb_x[0]=1; track_in=8'h00 gives lb_x[0]=0.
//  2. Program trk_en3=1, trk_sel3=1, then set lb_q=2'b10.
//     -> track_oe=8'h08, track_out[3]=1; track_oe=0 throughout programming.
//  3. Send a frame with a flipped parity bit.
//     -> cfg_err=1 after CHECK; cb_prgm_b_out=0; after prgm_b=1, the prior active config is unchanged.
//  4. Deassert the token (cb_prgm_b_in=1) for 5 cycles mid-frame.
//     -> shadow and cnt hold; the frame completes correctly after resume; total 33 shifted bits.
//  5. Set prgm_b=1 after 10 bits.
//     -> IDLE, cfg_err=1, no commit. Then assert reset (low) during SHIFT -> all outputs return to reset values asynchronously.
//  6. Chain two boxes via their tokens and send 66 bits.
//     -> the second box starts shifting only after the first box's cb_prgm_b_out=0; both commit on the prgm_b rise.

Source files
------------

// File: rtl/cb_param_cfg_pkg.sv
// Shared definitions for the connection-box configuration chain: state encoding,
// select widths, frame length and frame field offsets.
package cb_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } cfg_state_e;

  localparam int unsigned PARITY_POS = 0;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned frame_len(input int unsigned ni, input int unsigned nt,
                                            input int unsigned no);
    return ni * (sel_width(nt) + 1) + nt * (sel_width(no) + 1) + 1;
  endfunction

  // Input fields sit at the MSB end; field i spans {in_en, in_sel} with in_sel at the LSB.
  function automatic int unsigned in_field_lsb(input int unsigned ni, input int unsigned nt,
                                               input int unsigned no, input int unsigned i);
    return frame_len(ni, nt, no) - (i + 1) * (sel_width(nt) + 1);
  endfunction

  function automatic int unsigned trk_field_lsb(input int unsigned ni, input int unsigned nt,
                                                input int unsigned no, input int unsigned t);
    return frame_len(ni, nt, no) - ni * (sel_width(nt) + 1) - (t + 1) * (sel_width(no) + 1);
  endfunction

endpackage

// File: rtl/cb_param_cfg_if.sv
// Configuration/programming signal group of a connection box.
interface cb_param_cfg_if;
  logic prgm_b;
  logic cb_prgm_b;
  logic cb_prgm_b_in;
  logic cb_prgm_b_out;
  logic bit_in;
  logic cfg_done;
  logic cfg_err;

  modport master (
    output prgm_b, cb_prgm_b, cb_prgm_b_in, bit_in,
    input  cb_prgm_b_out, cfg_done, cfg_err
  );

  modport slave (
    input  prgm_b, cb_prgm_b, cb_prgm_b_in, bit_in,
    output cb_prgm_b_out, cfg_done, cfg_err
  );
endinterface

// File: rtl/cb_param_cfg_chain.sv
// Serial configuration chain: token-gated shift into a shadow frame, parity check,
// commit to the active frame on the end of global programming, decoded field outputs.
module cb_cfg_chain
  import cb_cfg_pkg::*;
#(
  parameter int unsigned NUM_TRACKS = 8,
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned NUM_OUT    = 2,
  localparam int unsigned TW = sel_width(NUM_TRACKS),
  localparam int unsigned QW = sel_width(NUM_OUT)
) (
  input  logic                             clk,
  input  logic                             reset,
  cb_param_cfg_if.slave                    cfg,
  output logic [NUM_IN-1:0]                in_en,
  output logic [NUM_IN-1:0][TW-1:0]        in_sel,
  output logic [NUM_TRACKS-1:0]            trk_en,
  output logic [NUM_TRACKS-1:0][QW-1:0]    trk_sel
);

  localparam int unsigned FL = frame_len(NUM_IN, NUM_TRACKS, NUM_OUT);
  localparam int unsigned CW = $clog2(FL);
  localparam logic [CW-1:0] CNT_LAST = CW'(FL - 1);

  cfg_state_e      state;
  logic [CW-1:0]   cnt;
  logic [FL-1:0]   shadow;
  logic [FL-1:0]   active;
  logic            sel;

  assign sel = !cfg.cb_prgm_b && !cfg.cb_prgm_b_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      shadow            <= '0;
      active            <= '0;
      cfg.cb_prgm_b_out <= 1'b1;
      cfg.cfg_done      <= 1'b0;
      cfg.cfg_err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cfg.cb_prgm_b_out <= 1'b1;
          // The first frame bit is taken on the entry edge, so SHIFT starts counting at 1.
          if (!cfg.prgm_b && sel) begin
            shadow <= {shadow[FL-2:0], cfg.bit_in};
            cnt    <= CW'(1);
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cfg.prgm_b) begin
            cnt         <= '0;
            cfg.cfg_err <= 1'b1;
            state       <= ST_IDLE;
          end else if (sel) begin
            shadow <= {shadow[FL-2:0], cfg.bit_in};
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= ST_CHECK;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        ST_CHECK: begin
          cfg.cb_prgm_b_out <= 1'b0;
          if (^shadow) begin
            cfg.cfg_err <= 1'b1;
            state       <= ST_ERR;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (cfg.prgm_b) begin
            active            <= shadow;
            cfg.cfg_done      <= 1'b1;
            cfg.cfg_err       <= 1'b0;
            cfg.cb_prgm_b_out <= 1'b1;
            state             <= ST_IDLE;
          end
        end
        ST_ERR: begin
          if (cfg.prgm_b) begin
            cfg.cb_prgm_b_out <= 1'b1;
            state             <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
    localparam int unsigned LSB = in_field_lsb(NUM_IN, NUM_TRACKS, NUM_OUT, gi);
    assign in_en[gi]  = active[LSB + TW];
    assign in_sel[gi] = active[LSB +: TW];
  end

  for (genvar gt = 0; gt < NUM_TRACKS; gt++) begin : g_trk
    localparam int unsigned LSB = trk_field_lsb(NUM_IN, NUM_TRACKS, NUM_OUT, gt);
    assign trk_en[gt]  = active[LSB + QW];
    assign trk_sel[gt] = active[LSB +: QW];
  end

endmodule

// File: rtl/cb_param_cfg.sv
// Connection box: track-to-input and output-to-track select muxes driven by the
// committed configuration; everything is held inactive while programming is in progress.
module cb_param_cfg
  import cb_cfg_pkg::*;
#(
  parameter int unsigned NUM_TRACKS = 8,
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned NUM_OUT    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  cb_param_cfg_if.slave         cfg,
  input  logic [NUM_TRACKS-1:0] track_in,
  output logic [NUM_TRACKS-1:0] track_out,
  output logic [NUM_TRACKS-1:0] track_oe,
  input  logic [NUM_OUT-1:0]    lb_q,
  output logic [NUM_IN-1:0]     lb_x
);

  localparam int unsigned TW = sel_width(NUM_TRACKS);
  localparam int unsigned QW = sel_width(NUM_OUT);

  logic [NUM_IN-1:0]             in_en;
  logic [NUM_IN-1:0][TW-1:0]     in_sel;
  logic [NUM_TRACKS-1:0]         trk_en;
  logic [NUM_TRACKS-1:0][QW-1:0] trk_sel;

  cb_cfg_chain #(
    .NUM_TRACKS (NUM_TRACKS),
    .NUM_IN     (NUM_IN),
    .NUM_OUT    (NUM_OUT)
  ) u_chain (
    .clk     (clk),
    .reset   (reset),
    .cfg     (cfg),
    .in_en   (in_en),
    .in_sel  (in_sel),
    .trk_en  (trk_en),
    .trk_sel (trk_sel)
  );

  // Out-of-range selects fall through to the disabled value.
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_x
    assign lb_x[gi] = (cfg.prgm_b && in_en[gi] && (32'(in_sel[gi]) < NUM_TRACKS))
                      ? track_in[in_sel[gi]] : 1'b0;
  end

  for (genvar gt = 0; gt < NUM_TRACKS; gt++) begin : g_t
    assign track_oe[gt]  = cfg.prgm_b && trk_en[gt] && (32'(trk_sel[gt]) < NUM_OUT);
    assign track_out[gt] = track_oe[gt] ? lb_q[trk_sel[gt]] : 1'b0;
  end

endmodule

// File: tb/tb_cb_param_cfg.sv
// Directed bench for cb_param_cfg: table-driven datapath vectors plus sequences for
// parity error, token pause, abort, async reset and a two-box token chain.
module tb_cb_param_cfg;

  localparam int FL = 33;

  typedef struct {
    int         phase;
    logic [7:0] trk;
    logic [1:0] q;
    logic [3:0] x;
    logic [7:0] oe;
    logic [7:0] out;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] track_in;
  logic [1:0] lb_q;
  logic [7:0] a_out, a_oe, b_out, b_oe;
  logic [3:0] a_x, b_x;
  int         total = 0;
  int         bad = 0;
  vec_t       vecs[13];

  always #5 clk = ~clk;

  cb_param_cfg_if cfg_a();
  cb_param_cfg_if cfg_b();

  assign cfg_b.prgm_b       = cfg_a.prgm_b;
  assign cfg_b.bit_in       = cfg_a.bit_in;
  assign cfg_b.cb_prgm_b_in = cfg_a.cb_prgm_b_out;

  cb_param_cfg #(.NUM_TRACKS(8), .NUM_IN(4), .NUM_OUT(2)) dut_a (
    .clk(clk), .reset(reset), .cfg(cfg_a), .track_in(track_in),
    .track_out(a_out), .track_oe(a_oe), .lb_q(lb_q), .lb_x(a_x)
  );

  cb_param_cfg #(.NUM_TRACKS(8), .NUM_IN(4), .NUM_OUT(2)) dut_b (
    .clk(clk), .reset(reset), .cfg(cfg_b), .track_in(track_in),
    .track_out(b_out), .track_oe(b_oe), .lb_q(lb_q), .lb_x(b_x)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] mk_frame(input logic [3:0] ien, input logic [11:0] isel,
                                           input logic [7:0] ten, input logic [7:0] tsel);
    logic [32:0] f;
    logic [3:0]  e;
    logic [11:0] s;
    logic [7:0]  te;
    logic [7:0]  ts;
    f = '0; e = ien; s = isel; te = ten; ts = tsel;
    for (int i = 0; i < 4; i++) begin
      f = {f[28:0], e[0], s[2:0]};
      e = e >> 1;
      s = s >> 3;
    end
    for (int t = 0; t < 8; t++) begin
      f = {f[30:0], te[0], ts[0]};
      te = te >> 1;
      ts = ts >> 1;
    end
    f = {f[31:0], ^f[31:0]};
    return f;
  endfunction

  task automatic send_bits(input logic [32:0] f, input int nbits, input int pause_at);
    logic [32:0] sh;
    sh = f;
    for (int n = 0; n < nbits; n++) begin
      if (n == pause_at) begin
        cfg_a.cb_prgm_b_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
          cfg_a.bit_in = ~cfg_a.bit_in;
          @(posedge clk); #1;
        end
        cfg_a.cb_prgm_b_in = 1'b0;
      end
      cfg_a.prgm_b = 1'b0;
      cfg_a.bit_in = sh[32];
      sh = sh << 1;
      @(posedge clk); #1;
    end
  endtask

  task automatic commit();
    cfg_a.prgm_b = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_phase(input int p);
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].phase == p) begin
        track_in = vecs[i].trk;
        lb_q     = vecs[i].q;
        #1;
        check($sformatf("p%0d v%0d lb_x", p, i), 32'(a_x), 32'(vecs[i].x));
        check($sformatf("p%0d v%0d track_oe", p, i), 32'(a_oe), 32'(vecs[i].oe));
        check($sformatf("p%0d v%0d track_out", p, i), 32'(a_out), 32'(vecs[i].out));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [32:0] f1, f2, f3, f4, fb;
    int w;

    // phase 1: in0 <- track5 ; phase 2: in0<-t5, in1<-t0, in3<-t7, track3 <- q1 ; phase 3: in1<-t3, track0 <- q0
    vecs[0]  = '{1, 8'h20, 2'b00, 4'h1, 8'h00, 8'h00};
    vecs[1]  = '{1, 8'h00, 2'b11, 4'h0, 8'h00, 8'h00};
    vecs[2]  = '{1, 8'hDF, 2'b11, 4'h0, 8'h00, 8'h00};
    vecs[3]  = '{1, 8'hFF, 2'b10, 4'h1, 8'h00, 8'h00};
    vecs[4]  = '{2, 8'h20, 2'b10, 4'h1, 8'h08, 8'h08};
    vecs[5]  = '{2, 8'h00, 2'b00, 4'h0, 8'h08, 8'h00};
    vecs[6]  = '{2, 8'h81, 2'b01, 4'hA, 8'h08, 8'h00};
    vecs[7]  = '{2, 8'hFF, 2'b11, 4'hB, 8'h08, 8'h08};
    vecs[8]  = '{2, 8'h5E, 2'b10, 4'h0, 8'h08, 8'h08};
    vecs[9]  = '{2, 8'hA1, 2'b01, 4'hB, 8'h08, 8'h00};
    vecs[10] = '{3, 8'h08, 2'b01, 4'h2, 8'h01, 8'h01};
    vecs[11] = '{3, 8'hF7, 2'b10, 4'h0, 8'h01, 8'h00};
    vecs[12] = '{3, 8'hFF, 2'b11, 4'h2, 8'h01, 8'h01};

    f1 = mk_frame(4'b0001, 12'h005, 8'h00, 8'h00);
    f2 = mk_frame(4'b1011, 12'hFC5, 8'h08, 8'h28);
    f3 = mk_frame(4'b1111, 12'h000, 8'hFF, 8'h00) ^ 33'h1;
    f4 = mk_frame(4'b0010, 12'h018, 8'h01, 8'h00);
    fb = mk_frame(4'b0100, 12'h180, 8'h80, 8'h80);

    reset = 1'b0;
    cfg_a.prgm_b = 1'b1; cfg_a.cb_prgm_b = 1'b0; cfg_a.cb_prgm_b_in = 1'b0; cfg_a.bit_in = 1'b0;
    cfg_b.cb_prgm_b = 1'b1;
    track_in = 8'hFF; lb_q = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    check("reset lb_x", 32'(a_x), 32'h0);
    check("reset track_oe", 32'(a_oe), 32'h0);
    check("reset track_out", 32'(a_out), 32'h0);
    check("reset token_out", 32'(cfg_a.cb_prgm_b_out), 32'h1);
    check("reset cfg_done", 32'(cfg_a.cfg_done), 32'h0);
    check("reset cfg_err", 32'(cfg_a.cfg_err), 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // single input enabled
    send_bits(f1, FL, -1);
    check("t1 token in CHECK", 32'(cfg_a.cb_prgm_b_out), 32'h1);
    @(posedge clk); #1;
    check("t1 token in DONE", 32'(cfg_a.cb_prgm_b_out), 32'h0);
    check("t1 done before commit", 32'(cfg_a.cfg_done), 32'h0);
    commit();
    check("t1 cfg_done", 32'(cfg_a.cfg_done), 32'h1);
    check("t1 token released", 32'(cfg_a.cb_prgm_b_out), 32'h1);
    run_phase(1);

    // mixed inputs plus one driven track
    send_bits(f2, FL, -1);
    @(posedge clk); #1;
    commit();
    run_phase(2);

    // bad parity: error, token still passed, previous config kept
    send_bits(f3, FL, -1);
    track_in = 8'hFF; lb_q = 2'b11; #1;
    check("t3 lb_x forced off", 32'(a_x), 32'h0);
    check("t3 track_oe forced off", 32'(a_oe), 32'h0);
    check("t3 track_out forced off", 32'(a_out), 32'h0);
    @(posedge clk); #1;
    check("t3 cfg_err", 32'(cfg_a.cfg_err), 32'h1);
    check("t3 token in ERR", 32'(cfg_a.cb_prgm_b_out), 32'h0);
    commit();
    check("t3 cfg_err sticky", 32'(cfg_a.cfg_err), 32'h1);
    check("t3 token released", 32'(cfg_a.cb_prgm_b_out), 32'h1);
    run_phase(2);

    // token paused 5 cycles mid-frame
    send_bits(f4, FL, 12);
    check("t4 token still high", 32'(cfg_a.cb_prgm_b_out), 32'h1);
    @(posedge clk); #1;
    check("t4 token in DONE", 32'(cfg_a.cb_prgm_b_out), 32'h0);
    commit();
    check("t4 cfg_err cleared", 32'(cfg_a.cfg_err), 32'h0);
    check("t4 cfg_done", 32'(cfg_a.cfg_done), 32'h1);
    run_phase(3);

    // abort after 10 bits
    send_bits(f2, 10, -1);
    cfg_a.prgm_b = 1'b1;
    @(posedge clk); #1;
    check("t5 abort cfg_err", 32'(cfg_a.cfg_err), 32'h1);
    check("t5 abort token", 32'(cfg_a.cb_prgm_b_out), 32'h1);
    run_phase(3);

    // asynchronous reset mid-shift
    send_bits(f2, 5, -1);
    #2 reset = 1'b0;
    #1;
    check("t5 rst cfg_done", 32'(cfg_a.cfg_done), 32'h0);
    check("t5 rst cfg_err", 32'(cfg_a.cfg_err), 32'h0);
    check("t5 rst token", 32'(cfg_a.cb_prgm_b_out), 32'h1);
    cfg_a.prgm_b = 1'b1; track_in = 8'hFF; lb_q = 2'b11;
    #1;
    check("t5 rst lb_x", 32'(a_x), 32'h0);
    check("t5 rst track_oe", 32'(a_oe), 32'h0);
    check("t5 rst track_out", 32'(a_out), 32'h0);
    check("box b untouched", 32'(b_oe), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // two-box chain
    cfg_b.cb_prgm_b = 1'b0;
    send_bits(f2, FL, -1);
    check("t6 b token idle", 32'(cfg_b.cb_prgm_b_out), 32'h1);
    w = 0;
    while (cfg_a.cb_prgm_b_out !== 1'b0 && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    check("t6 a token passed", 32'(cfg_a.cb_prgm_b_out), 32'h0);
    send_bits(fb, FL, -1);
    check("t6 b token in CHECK", 32'(cfg_b.cb_prgm_b_out), 32'h1);
    @(posedge clk); #1;
    check("t6 b token in DONE", 32'(cfg_b.cb_prgm_b_out), 32'h0);
    commit();
    check("t6 a cfg_done", 32'(cfg_a.cfg_done), 32'h1);
    check("t6 b cfg_done", 32'(cfg_b.cfg_done), 32'h1);
    check("t6 b cfg_err", 32'(cfg_b.cfg_err), 32'h0);
    track_in = 8'h40; lb_q = 2'b10; #1;
    check("t6 b lb_x", 32'(b_x), 32'h4);
    check("t6 b track_oe", 32'(b_oe), 32'h80);
    check("t6 b track_out", 32'(b_out), 32'h80);
    run_phase(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
